// File: rtl/i2s_pkg.sv
// Shared constants and the mixer-to-I2S sample conversion for the +3 audio path.
package i2s_pkg;

   localparam int          I2S_WORD_BITS   = 16;
   localparam int          I2S_FRAME_SLOTS = 32;
   localparam int          I2S_SLOT_BITS   = 5;
   localparam logic [15:0] I2S_MIDSCALE    = 16'h8000;

   // Unsigned 15-bit mixer level to 16-bit two's complement, midscale maps to zero.
   function automatic logic [I2S_WORD_BITS-1:0] to_i2s_word(input logic [14:0] level);
      return {level, 1'b0} ^ I2S_MIDSCALE;
   endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// Bit-clock generator: divides the system clock into sclk and flags each sclk falling edge.
module i2s_clkgen #(
   parameter int SCLK_DIV = 8
) (
   input  logic clock,
   input  logic reset,
   output logic sclk,
   output logic fall
);

   logic [7:0] count_q, count_d;
   logic       sclk_q, sclk_d;
   logic       terminal;

   always_comb begin
      terminal = (count_q == 8'(SCLK_DIV - 1));
      count_d  = terminal ? 8'd0 : count_q + 8'd1;
      sclk_d   = terminal ? ~sclk_q : sclk_q;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_q <= 8'd0;
         sclk_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         sclk_q  <= sclk_d;
      end
   end

   // Combinational so the transmitter updates on the very edge where sclk drops.
   assign fall = terminal & sclk_q;
   assign sclk = sclk_q;

endmodule

// File: rtl/i2s_tx.sv
// Philips I2S transmitter: latches a stereo pair once per frame and shifts it out MSB first.
module i2s_tx
   import i2s_pkg::*;
#(
   parameter int SCLK_DIV = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [14:0] left,
   input  logic [14:0] right,
   input  logic        mute,
   output logic        sclk,
   output logic        lrck,
   output logic        sdata,
   output logic        sample
);

   if (SCLK_DIV < 2 || SCLK_DIV > 255) begin : g_bad_div
      $error("i2s_tx: SCLK_DIV must be within 2..255");
   end

   logic                     fall;
   logic [I2S_SLOT_BITS-1:0] slot_q, slot_d;
   logic [31:0]              shift_q, shift_d;
   logic                     lrck_q, lrck_d;
   logic                     sdata_q, sdata_d;
   logic                     sample_q, sample_d;
   logic [15:0]              word_l, word_r;

   i2s_clkgen #(.SCLK_DIV(SCLK_DIV)) u_clkgen (
      .clock (clock),
      .reset (reset),
      .sclk  (sclk),
      .fall  (fall)
   );

   always_comb begin
      word_l   = mute ? 16'h0000 : to_i2s_word(left);
      word_r   = mute ? 16'h0000 : to_i2s_word(right);
      slot_d   = slot_q;
      shift_d  = shift_q;
      lrck_d   = lrck_q;
      sdata_d  = sdata_q;
      sample_d = 1'b0;
      if (fall) begin
         slot_d = slot_q + 5'd1;
         if (slot_d == 5'd0) begin
            shift_d  = {word_l, word_r};
            sample_d = 1'b1;
         end else begin
            shift_d = {shift_q[30:0], 1'b0};
         end
         sdata_d = shift_d[31];
         // Word select leads the data by one bit, as Philips I2S requires.
         lrck_d  = (slot_d >= 5'd15) && (slot_d <= 5'd30);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         slot_q   <= 5'd31;
         shift_q  <= 32'd0;
         lrck_q   <= 1'b0;
         sdata_q  <= 1'b0;
         sample_q <= 1'b0;
      end else begin
         slot_q   <= slot_d;
         shift_q  <= shift_d;
         lrck_q   <= lrck_d;
         sdata_q  <= sdata_d;
         sample_q <= sample_d;
      end
   end

   assign lrck   = lrck_q;
   assign sdata  = sdata_q;
   assign sample = sample_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Scoreboard bench for i2s_tx: a cycle-count reference model predicts frames, a monitor deserializes them.
module tb_i2s_tx;

   localparam int DIV   = 2;
   localparam int FRAME = 64 * DIV;

   logic        clock;
   logic        reset;
   logic [14:0] left;
   logic [14:0] right;
   logic        mute;
   logic        sclk;
   logic        lrck;
   logic        sdata;
   logic        sample;

   int          total_count;
   int          bad_count;
   int          cyc;
   int          frames_checked;
   int          bit_cnt;
   logic [31:0] frame_bits;
   logic [31:0] exp_q[$];

   i2s_tx #(.SCLK_DIV(DIV)) dut (
      .clock  (clock),
      .reset  (reset),
      .left   (left),
      .right  (right),
      .mute   (mute),
      .sclk   (sclk),
      .lrck   (lrck),
      .sdata  (sdata),
      .sample (sample)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // The transmitted word is the signed offset of the mixer level from midscale, times two.
   function automatic logic [15:0] ref_word(input logic [14:0] level, input logic m);
      int v;
      if (m) return 16'h0000;
      v = 2 * int'(level) - 32768;
      return 16'(v);
   endfunction

   function automatic bit is_latch_cycle(input int c);
      return (c >= 2 * DIV) && ((c - 2 * DIV) % FRAME == 0);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_count++;
      if (act !== exp) begin
         bad_count++;
         $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic applyStimulus(input logic [14:0] l, input logic [14:0] r, input logic m);
      left  = l;
      right = r;
      mute  = m;
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_sclk"},   32'(sclk),   32'd0);
      checkOutput({tag, "_lrck"},   32'(lrck),   32'd0);
      checkOutput({tag, "_sdata"},  32'(sdata),  32'd0);
      checkOutput({tag, "_sample"}, 32'(sample), 32'd0);
   endtask

   // Reference model: counts clocks since reset release and predicts each latched pair.
   always @(posedge clock) begin
      if (reset) begin
         cyc = 0;
         exp_q.delete();
      end else begin
         cyc = cyc + 1;
         if (is_latch_cycle(cyc))
            exp_q.push_back({ref_word(left, mute), ref_word(right, mute)});
      end
   end

   // Monitor: checks timing every clock and rebuilds each frame from the sclk rises.
   always @(posedge clock) begin
      int j;
      int s;
      #1;
      if (reset) begin
         bit_cnt = 0;
      end else begin
         checkOutput("sclk", 32'(sclk), 32'(((cyc / DIV) % 2) == 1));
         checkOutput("sample", 32'(sample), 32'(is_latch_cycle(cyc)));
         if (cyc > DIV && (cyc % (2 * DIV)) == DIV) begin
            j = (cyc / DIV - 1) / 2;
            s = (j - 1) % 32;
            if (s == 0) bit_cnt = 0;
            frame_bits[31 - s] = sdata;
            bit_cnt++;
            checkOutput($sformatf("lrck_slot%0d", s), 32'(lrck), 32'((s >= 15) && (s <= 30)));
            if (s == 31 && bit_cnt == 32) begin
               if (exp_q.size() == 0) begin
                  checkOutput("frame_unexpected", 32'd1, 32'd0);
               end else begin
                  checkOutput("frame_lr", frame_bits, exp_q.pop_front());
                  frames_checked++;
               end
            end
         end
      end
   end

   initial begin
      int target;
      total_count    = 0;
      bad_count      = 0;
      frames_checked = 0;
      bit_cnt        = 0;
      reset = 1'b1;
      applyStimulus(15'h7FFF, 15'h0000, 1'b0);
      repeat (3) @(negedge clock);
      checkResetOutputs("reset");
      reset = 1'b0;

      repeat (10) @(negedge clock);
      applyStimulus(15'h4000, 15'h2AAA, 1'b0);
      repeat (FRAME) @(negedge clock);
      applyStimulus(15'h7FFF, 15'h7FFF, 1'b1);
      repeat (FRAME) @(negedge clock);
      applyStimulus(15'h7FFF, 15'h1234, 1'b0);

      for (int i = 0; i < 4 * FRAME; i++) begin
         @(negedge clock);
         applyStimulus(15'($urandom), 15'($urandom), ($urandom_range(0, 7) == 0));
      end

      // Abort a frame while the DAC is in slot 20.
      target = (2 * DIV + 40 * DIV + 1) % FRAME;
      for (int i = 0; i < 2 * FRAME && (cyc % FRAME) != target; i++) @(negedge clock);
      checkOutput("reach_slot20", 32'(cyc % FRAME), 32'(target));
      #2 reset = 1'b1;
      #1 checkResetOutputs("midreset");
      repeat (3) @(negedge clock);
      reset = 1'b0;

      for (int i = 0; i < 3 * FRAME; i++) begin
         @(negedge clock);
         applyStimulus(15'($urandom), 15'($urandom), ($urandom_range(0, 7) == 0));
      end
      repeat (FRAME) @(negedge clock);
      checkOutput("frames_checked", 32'(frames_checked >= 9), 32'd1);

      $display("test done: total=%0d bad=%0d", total_count, bad_count);
      $finish;
   end

endmodule
